fft_job_ctrl: RTL



---
 rtl/fft_pkg.sv | 14 +
 rtl/bit_reverse.sv | 16 +
 rtl/fft_job_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the FP4 FFT job controller.
package fft_pkg;

  localparam int unsigned SAMPLE_W = 8;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

endpackage

// File: rtl/bit_reverse.sv
// Reverses the bit order of an address (natural order -> DIT input order).
module bit_reverse #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_addr,
  output logic [WIDTH-1:0] o_addr
);

  always_comb begin
    o_addr = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      o_addr[i] = i_addr[WIDTH-1-i];
    end
  end

endmodule

// File: rtl/fft_job_ctrl.sv
// Job sequencer for the FFT core: owns the working-memory port, tracks loaded
// samples, launches the core and aborts it with a watchdog if it hangs.
module fft_job_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned MAX_N          = 32,
  parameter int unsigned ADDR_WIDTH     = $clog2(MAX_N),
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_load_valid,
  output logic                  host_load_ready,
  input  logic [ADDR_WIDTH-1:0] host_load_addr,
  input  logic [SAMPLE_W-1:0]   host_load_data,
  input  logic                  host_start,
  input  logic                  host_clear,
  input  logic                  host_rd_req,
  output logic                  host_rd_ready,
  input  logic [ADDR_WIDTH-1:0] host_rd_addr,
  output logic                  host_rd_valid,
  output logic [SAMPLE_W-1:0]   host_rd_data,
  output logic                  busy,
  output logic                  irq_done,
  output logic                  start_err,
  output logic                  fault,
  output logic                  core_start,
  input  logic                  core_done,
  input  logic [ADDR_WIDTH-1:0] core_rd_addr,
  input  logic [ADDR_WIDTH-1:0] core_wr_addr,
  input  logic [SAMPLE_W-1:0]   core_wr_data,
  input  logic                  core_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [SAMPLE_W-1:0]   mem_rd_data,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [SAMPLE_W-1:0]   mem_wr_data
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);

  state_e            r_state;
  logic [MAX_N-1:0]  r_loaded;
  logic [WD_W-1:0]   r_wdog;
  logic              r_busy;
  logic              r_irq_done;
  logic              r_start_err;
  logic              r_fault;
  logic              r_core_start;
  logic              r_rd_valid;

  logic                  w_in_load;
  logic                  w_in_run;
  logic                  w_rd_open;
  logic                  w_load_acc;
  logic                  w_rd_acc;
  logic [ADDR_WIDTH-1:0] w_load_addr_rev;
  logic [MAX_N-1:0]      w_load_mask;
  logic                  w_all_loaded;
  logic                  w_timeout;

  assign w_in_load  = (r_state == ST_LOAD);
  assign w_in_run   = (r_state == ST_RUN);
  assign w_rd_open  = w_in_load || (r_state == ST_DONE) || (r_state == ST_FAULT);
  assign w_load_acc = host_load_valid && w_in_load;
  assign w_rd_acc   = host_rd_req && w_rd_open;
  assign w_timeout  = (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

  // A write accepted this cycle counts toward the start check.
  assign w_load_mask  = w_load_acc ? (MAX_N'(1) << host_load_addr) : '0;
  assign w_all_loaded = &(r_loaded | w_load_mask);

  bit_reverse #(.WIDTH(ADDR_WIDTH)) u_bitrev (
    .i_addr (host_load_addr),
    .o_addr (w_load_addr_rev)
  );

  assign host_load_ready = w_in_load;
  assign host_rd_ready   = w_rd_open;
  assign host_rd_valid   = r_rd_valid;
  assign host_rd_data    = r_rd_valid ? mem_rd_data : '0;
  assign busy            = r_busy;
  assign irq_done        = r_irq_done;
  assign start_err       = r_start_err;
  assign fault           = r_fault;
  assign core_start      = r_core_start;

  // Memory port grant: core owns it in RUN, host otherwise.
  always_comb begin
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    mem_rd_addr = '0;
    if (w_in_run) begin
      mem_wr_en   = core_wr_en;
      mem_wr_addr = core_wr_addr;
      mem_wr_data = core_wr_data;
      mem_rd_addr = core_rd_addr;
    end else begin
      if (w_load_acc) begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = w_load_addr_rev;
        mem_wr_data = host_load_data;
      end
      if (w_rd_acc) begin
        mem_rd_addr = host_rd_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_LOAD;
      r_loaded     <= '0;
      r_wdog       <= '0;
      r_busy       <= 1'b0;
      r_irq_done   <= 1'b0;
      r_start_err  <= 1'b0;
      r_fault      <= 1'b0;
      r_core_start <= 1'b0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_irq_done   <= 1'b0;
      r_start_err  <= 1'b0;
      r_core_start <= 1'b0;
      r_rd_valid   <= w_rd_acc;
      unique case (r_state)
        ST_LOAD: begin
          if (host_clear) begin
            r_loaded <= '0;
          end else begin
            r_loaded <= r_loaded | w_load_mask;
            if (host_start) begin
              if (w_all_loaded) begin
                r_state      <= ST_START;
                r_core_start <= 1'b1;
                r_busy       <= 1'b1;
                r_wdog       <= '0;
              end else begin
                r_start_err <= 1'b1;
              end
            end
          end
        end
        ST_START: begin
          r_state <= ST_RUN;
          r_wdog  <= '0;
        end
        ST_RUN: begin
          // Completion takes priority over a coincident timeout.
          if (core_done) begin
            r_state    <= ST_DONE;
            r_irq_done <= 1'b1;
            r_busy     <= 1'b0;
          end else if (w_timeout) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
          end
        end
        ST_DONE: begin
          if (host_clear) begin
            r_state  <= ST_LOAD;
            r_loaded <= '0;
          end
        end
        ST_FAULT: begin
          if (host_clear) begin
            r_state  <= ST_LOAD;
            r_loaded <= '0;
            r_fault  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule
